// File: rtl/arb21x10_pkg.sv
// rtl/arb21x10_pkg.sv - shared state type, source encoding and datapath width for arb21x10
package arb21x10_pkg;

  localparam int WIDTH = 10;

  localparam logic SRC_A = 1'b0;
  localparam logic SRC_B = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_OWN_A = 2'd1,
    ST_OWN_B = 2'd2
  } state_t;

endpackage

// File: rtl/mux21x10.sv
// rtl/mux21x10.sv - fixed-width 2:1 beat selector, passes i_a when i_s=0 and i_b when i_s=1
module mux21x10
  import arb21x10_pkg::*;
(
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_s,
  output logic [WIDTH-1:0] o_y
);

  assign o_y = i_s ? i_b : i_a;

endmodule

// File: rtl/arb21x10.sv
// rtl/arb21x10.sv - two-source burst arbiter with one registered output slot and saturating beat counters
// Define ARB21X10_ROUNDROBIN_EN for round-robin tie-break; otherwise A wins every tie.
module arb21x10
  import arb21x10_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [WIDTH-1:0] i_a_data,
  input  logic             i_a_valid,
  input  logic             i_a_last,
  output logic             o_a_ready,
  input  logic [WIDTH-1:0] i_b_data,
  input  logic             i_b_valid,
  input  logic             i_b_last,
  output logic             o_b_ready,
  output logic [WIDTH-1:0] o_out_data,
  output logic             o_out_valid,
  output logic             o_out_last,
  output logic             o_out_src,
  input  logic             i_out_ready,
  input  logic             i_clr_cnt,
  output logic [CNT_W-1:0] o_cnt_a,
  output logic [CNT_W-1:0] o_cnt_b
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           r_state;
  state_t           w_next_state;
  logic             r_last_grant;
  logic [WIDTH-1:0] r_out_data;
  logic             r_out_valid;
  logic             r_out_last;
  logic             r_out_src;
  logic [CNT_W-1:0] r_cnt_a;
  logic [CNT_W-1:0] r_cnt_b;

  logic             w_sel;
  logic             w_slot_free;
  logic             w_a_ready;
  logic             w_b_ready;
  logic             w_xfer_a;
  logic             w_xfer_b;
  logic             w_xfer;
  logic             w_xfer_last;
  logic             w_tie_pick_b;
  logic [WIDTH-1:0] w_mux_y;

  // The slot can take a beat when empty or when its current beat drains this cycle.
  assign w_slot_free = !r_out_valid || i_out_ready;
  assign w_sel       = (r_state == ST_OWN_B);
  assign w_a_ready   = (r_state == ST_OWN_A) && w_slot_free;
  assign w_b_ready   = (r_state == ST_OWN_B) && w_slot_free;
  assign w_xfer_a    = i_a_valid && w_a_ready;
  assign w_xfer_b    = i_b_valid && w_b_ready;
  assign w_xfer      = w_xfer_a || w_xfer_b;
  assign w_xfer_last = w_sel ? i_b_last : i_a_last;

`ifdef ARB21X10_ROUNDROBIN_EN
  assign w_tie_pick_b = (r_last_grant == SRC_A);
`else
  // Fixed priority: last_grant is still tracked but masked out of the decision.
  assign w_tie_pick_b = 1'b0 & r_last_grant;
`endif

  mux21x10 u_mux (
    .i_a (i_a_data),
    .i_b (i_b_data),
    .i_s (w_sel),
    .o_y (w_mux_y)
  );

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (i_a_valid && i_b_valid) begin
          w_next_state = w_tie_pick_b ? ST_OWN_B : ST_OWN_A;
        end else if (i_a_valid) begin
          w_next_state = ST_OWN_A;
        end else if (i_b_valid) begin
          w_next_state = ST_OWN_B;
        end
      end
      ST_OWN_A: if (w_xfer_a && i_a_last) w_next_state = ST_IDLE;
      ST_OWN_B: if (w_xfer_b && i_b_last) w_next_state = ST_IDLE;
      default:  w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state      <= ST_IDLE;
      r_last_grant <= SRC_B;
    end else begin
      r_state <= w_next_state;
      if (w_xfer && w_xfer_last) r_last_grant <= w_sel;
    end
  end

  // A drain and a load in the same cycle keep the slot full with the new beat.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_out_src   <= SRC_A;
    end else if (w_xfer) begin
      r_out_data  <= w_mux_y;
      r_out_valid <= 1'b1;
      r_out_last  <= w_xfer_last;
      r_out_src   <= w_sel;
    end else if (i_out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset || i_clr_cnt) begin
      r_cnt_a <= '0;
      r_cnt_b <= '0;
    end else begin
      if (w_xfer_a && (r_cnt_a != CNT_MAX)) r_cnt_a <= r_cnt_a + CNT_W'(1);
      if (w_xfer_b && (r_cnt_b != CNT_MAX)) r_cnt_b <= r_cnt_b + CNT_W'(1);
    end
  end

  assign o_a_ready   = w_a_ready;
  assign o_b_ready   = w_b_ready;
  assign o_out_data  = r_out_data;
  assign o_out_valid = r_out_valid;
  assign o_out_last  = r_out_last;
  assign o_out_src   = r_out_src;
  assign o_cnt_a     = r_cnt_a;
  assign o_cnt_b     = r_cnt_b;

endmodule
